unidade_busca: RTL and testbench

//  Fetch sequencer for the Yousei core. Owns the program counter (PC) that

---
 rtl/yousei_pkg.sv | 27 ++
 rtl/proximo_pc.sv | 48 ++++
 rtl/unidade_busca.sv | 156 +++++++++++++++
 tb/tb_unidade_busca.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yousei_pkg.sv
// Shared types and constants for the Yousei core fetch path.
//   Provides the fetch FSM state encoding, the decoder opcode/funct values the
//   fetch controls come from, and default sizing for the fetch unit.
package yousei_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned MEM_DEPTH_DEF = 123;
    localparam int unsigned MD_CYCLES_DEF = 4;

    // Decoder opcodes/functs that produce the fetch control pulses
    localparam logic [5:0] OP_JUMP    = 6'b000101;
    localparam logic [5:0] OP_BEQ     = 6'b001010;
    localparam logic [5:0] OP_JR      = 6'b010011;
    localparam logic [5:0] OP_IN      = 6'b001000;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_BUSY    = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_HALT    = 3'd4,
        ST_FAULT   = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/proximo_pc.sv
// Combinational next-PC selection and instruction-memory range check.
//   pc_i                  current PC
//   jump_reg_i/reg_addr_i jr request and register target (highest priority)
//   jump_i/jump_addr_i    jump request and immediate target
//   branch_i/branch_addr_i taken beq and immediate target
//   npc_o                 selected next PC (PC+1 when no redirect)
//   halt_hit_o            selected source is a jump to the current PC
//   oor_o                 selected next PC lies outside 0..MEM_DEPTH-1
module proximo_pc
    import yousei_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_reg_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic [ADDR_W-1:0] npc_o,
    output logic              halt_hit_o,
    output logic              oor_o
);

    // One extra bit so PC+1 at the top of the address space cannot wrap into range
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_DEPTH);

    logic [ADDR_W:0] npc_w;

    // Priority mux: jr > jump > branch > sequential
    always_comb begin
        npc_w = {1'b0, pc_i} + (ADDR_W+1)'(1);
        if (jump_reg_i) begin
            npc_w = {1'b0, reg_addr_i};
        end else if (jump_i) begin
            npc_w = {1'b0, jump_addr_i};
        end else if (branch_i) begin
            npc_w = {1'b0, branch_addr_i};
        end
    end

    assign npc_o      = npc_w[ADDR_W-1:0];
    assign halt_hit_o = !jump_reg_i && jump_i && (jump_addr_i == pc_i);
    assign oor_o      = (npc_w >= LIMIT);

endmodule

// File: rtl/unidade_busca.sv
// Fetch sequencer for the Yousei core: owns the PC, stalls for mult/div and
// user input, and parks the core on halt or out-of-range fetch.
//   Clock, Reset                 rising-edge clock, async active-high reset
//   Jump/JumpAddr                jump request and target
//   Branch/BranchAddr            taken beq and target
//   JumpReg/RegAddr              jr request and register target
//   MulDiv                       mult/div issued this cycle
//   InReq/InEnter                'in' issued / user confirm level
//   Endereco                     PC to instruction memory
//   Enable                       instruction on the bus retires this cycle
//   Halted, Fault                core parked by halt / by out-of-range PC
module unidade_busca
    import yousei_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpAddr,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchAddr,
    input  logic              JumpReg,
    input  logic [ADDR_W-1:0] RegAddr,
    input  logic              MulDiv,
    input  logic              InReq,
    input  logic              InEnter,
    output logic [ADDR_W-1:0] Endereco,
    output logic              Enable,
    output logic              Halted,
    output logic              Fault
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_run;
    logic              redirect;
    logic [ADDR_W-1:0] npc;
    logic              halt_hit;
    logic              oor;

    assign in_run   = (state_q == ST_RUN);
    // Redirect controls only count in RUN; elsewhere the mux yields PC+1
    assign redirect = in_run && (JumpReg || Jump || Branch);

    proximo_pc #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_proximo_pc (
        .pc_i          (pc_q),
        .jump_reg_i    (JumpReg && in_run),
        .reg_addr_i    (RegAddr),
        .jump_i        (Jump && in_run),
        .jump_addr_i   (JumpAddr),
        .branch_i      (Branch && in_run),
        .branch_addr_i (BranchAddr),
        .npc_o         (npc),
        .halt_hit_o    (halt_hit),
        .oor_o         (oor)
    );

    // State, PC and stall counter registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, next-PC and counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    // A redirect combined with a stall request drops the stall
                    if (oor) state_d = ST_FAULT;
                    else     pc_d    = npc;
                end else if (MulDiv) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MD_CYCLES);
                end else if (InReq) begin
                    state_d = ST_WAIT_IN;
                end else if (oor) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d = npc;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (oor) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = npc;
                    end
                end
            end
            ST_WAIT_IN: begin
                if (InEnter) begin
                    if (oor) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = npc;
                    end
                end
            end
            ST_HALT, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state; Enable follows InEnter while waiting for the user
    always_comb begin
        Enable = 1'b0;
        Halted = 1'b0;
        Fault  = 1'b0;
        unique case (state_q)
            ST_RUN:     Enable = 1'b1;
            ST_WAIT_IN: Enable = InEnter;
            ST_HALT:    Halted = 1'b1;
            ST_FAULT:   Fault  = 1'b1;
            default:    Enable = 1'b0;
        endcase
    end

    assign Endereco = pc_q;

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

    localparam int unsigned ADDR_W = 32;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              Jump = 1'b0, Branch = 1'b0, JumpReg = 1'b0;
    logic              MulDiv = 1'b0, InReq = 1'b0, InEnter = 1'b0;
    logic [ADDR_W-1:0] JumpAddr = '0, BranchAddr = '0, RegAddr = '0;
    logic [ADDR_W-1:0] Endereco;
    logic              Enable, Halted, Fault;

    int vectors     = 0;
    int miscompares = 0;

    unidade_busca #(.ADDR_W(32), .MEM_DEPTH(123), .MD_CYCLES(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Jump       (Jump),
        .JumpAddr   (JumpAddr),
        .Branch     (Branch),
        .BranchAddr (BranchAddr),
        .JumpReg    (JumpReg),
        .RegAddr    (RegAddr),
        .MulDiv     (MulDiv),
        .InReq      (InReq),
        .InEnter    (InEnter),
        .Endereco   (Endereco),
        .Enable     (Enable),
        .Halted     (Halted),
        .Fault      (Fault)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_ctl();
        Jump = 0; Branch = 0; JumpReg = 0; MulDiv = 0; InReq = 0; InEnter = 0;
        JumpAddr = '0; BranchAddr = '0; RegAddr = '0;
    endtask

    // Leaves the DUT in BOOT, sampled 1 time unit after a rising edge
    task automatic do_reset();
        clear_ctl();
        Reset = 1;
        #3;
        @(posedge Clock);
        #1;
        Reset = 0;
    endtask

    task automatic goto_pc(input logic [ADDR_W-1:0] a);
        Jump = 1; JumpAddr = a;
        tick();
        Jump = 0; JumpAddr = '0;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] exp_pc [4];
        exp_pc = '{32'd0, 32'd1, 32'd2, 32'd3};
        clear_ctl();
        Reset = 1;
        #2;
        vectors++;
        if ({Endereco, Enable, Halted, Fault} !== {32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_state: pc=%0d en=%b h=%b f=%b want pc=0 en=0 h=0 f=0", Endereco, Enable, Halted, Fault);
        end
        @(posedge Clock); #1; Reset = 0;
        vectors++;
        if (Endereco !== 32'd0 || Enable !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_cycle: pc=%0d en=%b want pc=0 en=0", Endereco, Enable);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (Endereco !== exp_pc[i] || Enable !== 1'b1) begin
                miscompares++;
                $display("FAIL free_run[%0d]: pc=%0d en=%b want pc=%0d en=1", i, Endereco, Enable, exp_pc[i]);
            end
        end
    endtask

    task automatic test_jump_halt();
        do_reset();
        tick(); tick(); tick();
        vectors++;
        if (Endereco !== 32'd2) begin
            miscompares++;
            $display("FAIL jump_setup: pc=%0d want 2", Endereco);
        end
        Jump = 1; JumpAddr = 32'd40;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd40 || Enable !== 1'b1 || Halted !== 1'b0) begin
            miscompares++;
            $display("FAIL jump_40: pc=%0d en=%b h=%b want pc=40 en=1 h=0", Endereco, Enable, Halted);
        end
        goto_pc(32'd55);
        Jump = 1; JumpAddr = 32'd55;
        tick();
        for (int i = 0; i < 20; i++) begin
            // Controls while halted must be ignored
            Jump = 1; JumpAddr = 32'd3; MulDiv = i[0];
            vectors++;
            if (Endereco !== 32'd55 || Halted !== 1'b1 || Enable !== 1'b0 || Fault !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold[%0d]: pc=%0d h=%b en=%b f=%b want pc=55 h=1 en=0 f=0", i, Endereco, Halted, Enable, Fault);
            end
            tick();
        end
        clear_ctl();
    endtask

    task automatic test_muldiv();
        do_reset();
        tick();
        goto_pc(32'd17);
        MulDiv = 1;
        vectors++;
        if (Endereco !== 32'd17 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL md_issue: pc=%0d en=%b want pc=17 en=1", Endereco, Enable);
        end
        tick();
        MulDiv = 0;
        Jump = 1; JumpAddr = 32'd5;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (Endereco !== 32'd17 || Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL md_busy[%0d]: pc=%0d en=%b want pc=17 en=0", i, Endereco, Enable);
            end
            tick();
        end
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd18 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL md_resume: pc=%0d en=%b want pc=18 en=1", Endereco, Enable);
        end
    endtask

    task automatic test_in();
        do_reset();
        tick();
        goto_pc(32'd41);
        InReq = 1;
        tick();
        InReq = 0;
        Branch = 1; BranchAddr = 32'd7;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (Endereco !== 32'd41 || Enable !== 1'b0) begin
                miscompares++;
                $display("FAIL in_wait[%0d]: pc=%0d en=%b want pc=41 en=0", i, Endereco, Enable);
            end
            tick();
        end
        Branch = 0;
        InEnter = 1;
        #1;
        vectors++;
        if (Endereco !== 32'd41 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL in_enter: pc=%0d en=%b want pc=41 en=1", Endereco, Enable);
        end
        tick();
        InEnter = 0;
        vectors++;
        if (Endereco !== 32'd42 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL in_resume: pc=%0d en=%b want pc=42 en=1", Endereco, Enable);
        end
        InEnter = 1;
        tick();
        InEnter = 0;
        vectors++;
        if (Endereco !== 32'd43 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL in_enter_ignored: pc=%0d en=%b want pc=43 en=1", Endereco, Enable);
        end
    endtask

    task automatic test_priority();
        do_reset();
        tick();
        goto_pc(32'd10);
        JumpReg = 1; RegAddr = 32'd53; Jump = 1; JumpAddr = 32'd3; Branch = 1; BranchAddr = 32'd32;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd53) begin
            miscompares++;
            $display("FAIL prio_jr: pc=%0d want 53", Endereco);
        end
        Branch = 1; BranchAddr = 32'd32;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd32) begin
            miscompares++;
            $display("FAIL branch_only: pc=%0d want 32", Endereco);
        end
        Jump = 1; JumpAddr = 32'd7; Branch = 1; BranchAddr = 32'd9;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd7) begin
            miscompares++;
            $display("FAIL prio_jump_over_branch: pc=%0d want 7", Endereco);
        end
        Jump = 1; JumpAddr = 32'd60; MulDiv = 1;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd60 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_drops_stall: pc=%0d en=%b want pc=60 en=1", Endereco, Enable);
        end
        tick();
        vectors++;
        if (Endereco !== 32'd61) begin
            miscompares++;
            $display("FAIL after_dropped_stall: pc=%0d want 61", Endereco);
        end
        JumpReg = 1; RegAddr = 32'd61;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd61 || Halted !== 1'b0 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL jr_self_no_halt: pc=%0d h=%b en=%b want pc=61 h=0 en=1", Endereco, Halted, Enable);
        end
    endtask

    task automatic test_fault();
        do_reset();
        tick();
        goto_pc(32'd121);
        tick();
        vectors++;
        if (Endereco !== 32'd122 || Enable !== 1'b1 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL last_word: pc=%0d en=%b f=%b want pc=122 en=1 f=0", Endereco, Enable, Fault);
        end
        tick();
        Jump = 1; JumpAddr = 32'd3;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (Endereco !== 32'd122 || Fault !== 1'b1 || Enable !== 1'b0 || Halted !== 1'b0) begin
                miscompares++;
                $display("FAIL fault_hold[%0d]: pc=%0d f=%b en=%b h=%b want pc=122 f=1 en=0 h=0", i, Endereco, Fault, Enable, Halted);
            end
            tick();
        end
        do_reset();
        tick();
        Branch = 1; BranchAddr = 32'd123;
        tick();
        clear_ctl();
        vectors++;
        if (Endereco !== 32'd0 || Fault !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_oor: pc=%0d f=%b want pc=0 f=1", Endereco, Fault);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        tick();
        goto_pc(32'd10);
        MulDiv = 1;
        tick();
        MulDiv = 0;
        tick();
        #2;
        Reset = 1;
        #1;
        vectors++;
        if ({Endereco, Enable, Halted, Fault} !== {32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset_busy: pc=%0d en=%b h=%b f=%b want pc=0 en=0 h=0 f=0", Endereco, Enable, Halted, Fault);
        end
        @(posedge Clock); #1; Reset = 0;
        vectors++;
        if (Endereco !== 32'd0 || Enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reboot: pc=%0d en=%b want pc=0 en=0", Endereco, Enable);
        end
        tick(); tick();
        vectors++;
        if (Endereco !== 32'd1 || Enable !== 1'b1) begin
            miscompares++;
            $display("FAIL reboot_run: pc=%0d en=%b want pc=1 en=1", Endereco, Enable);
        end
    endtask

    initial begin
        test_reset();
        test_jump_halt();
        test_muldiv();
        test_in();
        test_priority();
        test_fault();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
